// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared definitions for the calculator keypad encoder and the
//               control logic: funct encodings, key codes, FSM states, op
//               encoding and key classification helpers.
//               Optional feature macro: CALC_MULDIV_EN (enables * and / keys).
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

   // Encoder FSM states
   typedef enum logic [1:0] {
      S_A     = 2'd0,
      S_B     = 2'd1,
      S_ISSUE = 2'd2,
      S_CHAIN = 2'd3
   } state_t;

   // Arithmetic operation selected by the operator keys
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   // funct encodings shared with the control logic (MSB set = fresh operands)
   localparam logic [2:0] FUNCT_ADD       = 3'b100;
   localparam logic [2:0] FUNCT_SUB       = 3'b101;
   localparam logic [2:0] FUNCT_MULT      = 3'b110;
   localparam logic [2:0] FUNCT_DIV       = 3'b111;
   localparam logic [2:0] FUNCT_ADD_PREV  = 3'b000;
   localparam logic [2:0] FUNCT_SUB_PREV  = 3'b001;
   localparam logic [2:0] FUNCT_MULT_PREV = 3'b010;
   localparam logic [2:0] FUNCT_DIV_PREV  = 3'b011;

   // Key codes (0-9 are digits)
   localparam logic [3:0] KEY_ADD = 4'hA;
   localparam logic [3:0] KEY_SUB = 4'hB;
   localparam logic [3:0] KEY_MUL = 4'hC;
   localparam logic [3:0] KEY_DIV = 4'hD;
   localparam logic [3:0] KEY_EQ  = 4'hE;
   localparam logic [3:0] KEY_CLR = 4'hF;

   function automatic logic is_digit(input logic [3:0] k);
      return (k <= 4'd9);
   endfunction

   // Multiply/divide keys only count as operators when the feature is built in;
   // otherwise they fall through every decode and have no effect.
   function automatic logic is_operator(input logic [3:0] k);
`ifdef CALC_MULDIV_EN
      return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL) || (k == KEY_DIV);
`else
      return (k == KEY_ADD) || (k == KEY_SUB);
`endif
   endfunction

   // A..D map to 00..11: low two key bits rotated by two
   function automatic logic [1:0] key_to_op(input logic [3:0] k);
      return k[1:0] + 2'd2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/calc_digit_accum.sv
`default_nettype none
// ============================================================================
// Module      : calc_digit_accum
// Description : Combinational decimal digit accumulation acc*10 + d, computed
//               four bits wider than the operand so overflow is detectable.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_digit_accum #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [3:0]       digit,
   output logic [WIDTH-1:0] result,
   output logic             overflow
);

   localparam logic [WIDTH+3:0] TEN = (WIDTH+4)'(10);

   logic [WIDTH+3:0] wide;

   // (2^WIDTH-1)*10 + 9 always fits in WIDTH+4 bits
   assign wide     = ({4'b0000, acc} * TEN) + {{WIDTH{1'b0}}, digit};
   assign result   = wide[WIDTH-1:0];
   assign overflow = |wide[WIDTH+3:WIDTH];

endmodule
`default_nettype wire

// File: rtl/calc_key_encoder.sv
`default_nettype none
// ============================================================================
// Module      : calc_key_encoder
// Description : Keypad command encoder. Accumulates decimal operands from key
//               strokes and issues a 3-bit funct with operands over a
//               valid/ready handshake, choosing fresh (1xx) or chained (0xx)
//               opcodes from the key history.
//               Optional feature macro: CALC_MULDIV_EN (multiply/divide keys).
// Revision    : 1.0 - initial release
// ============================================================================
module calc_key_encoder
   import calc_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             key_valid,
   input  logic [3:0]       key_code,
   output logic             key_ready,
   output logic             instr_valid,
   input  logic             instr_ready,
   output logic [2:0]       funct,
   output logic [WIDTH-1:0] operand_a,
   output logic [WIDTH-1:0] operand_b,
   output logic             overflow
);

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] a_reg;
   logic [1:0]       op;
   logic             chain;

   logic [WIDTH-1:0] accum_result;
   logic             accum_ovf;

   calc_digit_accum #(.WIDTH(WIDTH)) u_accum (
      .acc      (acc),
      .digit    (key_code),
      .result   (accum_result),
      .overflow (accum_ovf)
   );

   // Keys are refused only while an instruction is waiting downstream
   assign key_ready = (state != S_ISSUE);

   // Encoder FSM, operand registers and registered instruction outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_A;
         acc         <= '0;
         a_reg       <= '0;
         op          <= OP_ADD;
         chain       <= 1'b0;
         instr_valid <= 1'b0;
         funct       <= 3'b000;
         operand_a   <= '0;
         operand_b   <= '0;
         overflow    <= 1'b0;
      end else if (state == S_ISSUE) begin
         // Instruction outputs hold until the downstream side takes them
         if (instr_ready) begin
            instr_valid <= 1'b0;
            acc         <= '0;
            state       <= S_CHAIN;
         end
      end else if (key_valid) begin
         if (key_code == KEY_CLR) begin
            acc      <= '0;
            a_reg    <= '0;
            overflow <= 1'b0;
            chain    <= 1'b0;
            state    <= S_A;
         end else begin
            case (state)
               S_A: begin
                  if (is_digit(key_code)) begin
                     if (accum_ovf) overflow <= 1'b1;
                     else           acc      <= accum_result;
                  end else if (is_operator(key_code)) begin
                     a_reg <= acc;
                     op    <= key_to_op(key_code);
                     acc   <= '0;
                     chain <= 1'b0;
                     state <= S_B;
                  end
               end
               S_B: begin
                  if (is_digit(key_code)) begin
                     if (accum_ovf) overflow <= 1'b1;
                     else           acc      <= accum_result;
                  end else if (is_operator(key_code)) begin
                     op <= key_to_op(key_code);
                  end else if (key_code == KEY_EQ) begin
                     funct       <= {~chain, op};
                     operand_a   <= chain ? '0 : a_reg;
                     operand_b   <= acc;
                     instr_valid <= 1'b1;
                     state       <= S_ISSUE;
                  end
               end
               S_CHAIN: begin
                  if (is_digit(key_code)) begin
                     // A fresh digit abandons the previous result
                     acc   <= WIDTH'(key_code);
                     chain <= 1'b0;
                     state <= S_A;
                  end else if (is_operator(key_code)) begin
                     op    <= key_to_op(key_code);
                     chain <= 1'b1;
                     acc   <= '0;
                     state <= S_B;
                  end
               end
               default: state <= S_A;
            endcase
         end
      end
   end

endmodule
`default_nettype wire
